// File: rtl/sd_cmd_controller.sv
// SD host command controller: builds the 48-bit command frame with a serial CRC7,
// hands it to the PHY, and waits for a none/short/long response with a timeout.
// Handshakes: oStrobe_out stays high until the PHY answers with iAck_in;
// iStrobe_in is accepted in WAIT_RSP and is answered by a one-cycle oAck_out.
// Optional macro SD_RSP_CRC_CHECK_EN adds CRC7 checking of short responses.
module sd_cmd_controller #(
  parameter int RSP_W = 136,
  parameter int TO_W  = 16
) (
  input  logic              iClock_host,
  input  logic              iReset_n,
  input  logic              iNew_command,
  input  logic [5:0]        iCmd_index,
  input  logic [31:0]       iCmd_argument,
  input  logic [1:0]        iRsp_type,
  input  logic [TO_W-1:0]   iTimeout_cycles,
  output logic [47:0]       oCmd_out,
  output logic              oStrobe_out,
  input  logic              iAck_in,
  input  logic [RSP_W-1:0]  iCmd_in,
  input  logic              iStrobe_in,
  output logic              oAck_out,
  output logic [RSP_W-1:0]  oResponse,
  output logic              oIdle_out,
  output logic              oCommand_complete,
  output logic              oCommand_index_error,
  output logic              oTimeout_error,
  output logic              oCrc_error
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CRC      = 3'd1,
    S_SEND     = 3'd2,
    S_WAIT_RSP = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [TO_W-1:0] ONE_TO = TO_W'(1);

  state_t             r_state;
  state_t             w_next;
  logic [5:0]         r_index;
  logic [31:0]        r_arg;
  logic [1:0]         r_rsp_type;
  logic [TO_W-1:0]    r_timeout;
  logic [39:0]        r_shift;
  logic [6:0]         r_crc;
  logic [5:0]         r_bit_cnt;
  logic [TO_W-1:0]    r_to_cnt;
  logic [47:0]        r_cmd_out;
  logic               r_strobe;
  logic               r_ack;
  logic [RSP_W-1:0]   r_response;
  logic               r_idle;
  logic               r_complete;
  logic               r_idx_err;
  logic               r_to_err;

  logic               w_crc_fb;
  logic [6:0]         w_crc_next;
  logic               w_timeout_hit;
  logic               w_rsp_short;

  // Serial CRC7 (x^7 + x^3 + 1): feedback taps land on bits 3 and 0.
  assign w_crc_fb      = r_shift[39] ^ r_crc[6];
  assign w_crc_next    = {r_crc[5:0], 1'b0} ^ (w_crc_fb ? 7'h09 : 7'h00);
  assign w_timeout_hit = (r_timeout != '0) && (r_to_cnt == (r_timeout - ONE_TO));
  assign w_rsp_short   = (r_rsp_type != 2'b10);

  always_ff @(posedge iClock_host) begin
    if (!iReset_n) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (iNew_command) w_next = S_CRC;
      S_CRC:      if (r_bit_cnt == 6'd40) w_next = S_SEND;
      S_SEND:     if (iAck_in) w_next = (r_rsp_type == 2'b00) ? S_DONE : S_WAIT_RSP;
      S_WAIT_RSP: if (iStrobe_in || w_timeout_hit) w_next = S_DONE;
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iClock_host) begin
    if (!iReset_n) begin
      r_index    <= '0;
      r_arg      <= '0;
      r_rsp_type <= '0;
      r_timeout  <= '0;
      r_shift    <= '0;
      r_crc      <= '0;
      r_bit_cnt  <= '0;
      r_to_cnt   <= '0;
      r_cmd_out  <= '0;
      r_strobe   <= 1'b0;
      r_ack      <= 1'b0;
      r_response <= '0;
      r_idle     <= 1'b1;
      r_complete <= 1'b0;
      r_idx_err  <= 1'b0;
      r_to_err   <= 1'b0;
    end else begin
      r_ack      <= 1'b0;
      r_complete <= (w_next == S_DONE);
      r_idle     <= (w_next == S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (iNew_command) begin
            r_index    <= iCmd_index;
            r_arg      <= iCmd_argument;
            r_rsp_type <= iRsp_type;
            r_timeout  <= iTimeout_cycles;
            r_shift    <= {2'b01, iCmd_index, iCmd_argument};
            r_crc      <= '0;
            r_bit_cnt  <= '0;
            r_idx_err  <= 1'b0;
            r_to_err   <= 1'b0;
          end
        end
        S_CRC: begin
          // 40 shift cycles, then one more cycle to publish the frame.
          if (r_bit_cnt != 6'd40) begin
            r_crc     <= w_crc_next;
            r_shift   <= {r_shift[38:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 6'd1;
          end else begin
            r_cmd_out <= {2'b01, r_index, r_arg, r_crc, 1'b1};
            r_strobe  <= 1'b1;
          end
        end
        S_SEND: begin
          if (iAck_in) begin
            r_strobe <= 1'b0;
            r_to_cnt <= '0;
          end
        end
        S_WAIT_RSP: begin
          if (r_to_cnt != {TO_W{1'b1}}) r_to_cnt <= r_to_cnt + ONE_TO;
          // A response arriving on the expiry cycle takes priority.
          if (iStrobe_in) begin
            r_ack <= 1'b1;
            if (w_rsp_short) r_response <= {{(RSP_W-48){1'b0}}, iCmd_in[47:0]};
            else             r_response <= iCmd_in;
            if (r_rsp_type == 2'b01) r_idx_err <= (iCmd_in[45:40] != r_index);
          end else if (w_timeout_hit) begin
            r_to_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SD_RSP_CRC_CHECK_EN
  function automatic logic [6:0] f_crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  logic r_crc_err;
  logic w_rsp_crc_bad;

  assign w_rsp_crc_bad = (f_crc7(iCmd_in[47:8]) != iCmd_in[7:1]);

  always_ff @(posedge iClock_host) begin
    if (!iReset_n) begin
      r_crc_err <= 1'b0;
    end else if (r_state == S_IDLE && iNew_command) begin
      r_crc_err <= 1'b0;
    end else if (r_state == S_WAIT_RSP && iStrobe_in && w_rsp_short) begin
      r_crc_err <= w_rsp_crc_bad;
    end
  end

  assign oCrc_error = r_crc_err;
`else
  assign oCrc_error = 1'b0;
`endif

  assign oCmd_out             = r_cmd_out;
  assign oStrobe_out          = r_strobe;
  assign oAck_out             = r_ack;
  assign oResponse            = r_response;
  assign oIdle_out            = r_idle;
  assign oCommand_complete    = r_complete;
  assign oCommand_index_error = r_idx_err;
  assign oTimeout_error       = r_to_err;

endmodule

// File: tb/tb_sd_cmd_controller.sv
// Bench for sd_cmd_controller: directed and random commands, a reference model
// built on CRC7 polynomial long division, and a queue-based output monitor.
`timescale 1ns/1ps
module tb_sd_cmd_controller;
  localparam int RSP_W = 136;
  localparam int TO_W  = 16;

  logic              clk = 1'b0;
  logic              iReset_n;
  logic              iNew_command;
  logic [5:0]        iCmd_index;
  logic [31:0]       iCmd_argument;
  logic [1:0]        iRsp_type;
  logic [TO_W-1:0]   iTimeout_cycles;
  logic [47:0]       oCmd_out;
  logic              oStrobe_out;
  logic              iAck_in;
  logic [RSP_W-1:0]  iCmd_in;
  logic              iStrobe_in;
  logic              oAck_out;
  logic [RSP_W-1:0]  oResponse;
  logic              oIdle_out;
  logic              oCommand_complete;
  logic              oCommand_index_error;
  logic              oTimeout_error;
  logic              oCrc_error;

  int n_vec  = 0;
  int n_miss = 0;

  logic [47:0]      exp_cmd_q[$];
  logic [RSP_W-1:0] exp_rsp_q[$];
  logic [0:0]       exp_crc_q[$];
  logic [2:0]       exp_done_q[$];

  sd_cmd_controller #(.RSP_W(RSP_W), .TO_W(TO_W)) dut (
    .iClock_host(clk), .iReset_n(iReset_n), .iNew_command(iNew_command),
    .iCmd_index(iCmd_index), .iCmd_argument(iCmd_argument), .iRsp_type(iRsp_type),
    .iTimeout_cycles(iTimeout_cycles), .oCmd_out(oCmd_out), .oStrobe_out(oStrobe_out),
    .iAck_in(iAck_in), .iCmd_in(iCmd_in), .iStrobe_in(iStrobe_in), .oAck_out(oAck_out),
    .oResponse(oResponse), .oIdle_out(oIdle_out), .oCommand_complete(oCommand_complete),
    .oCommand_index_error(oCommand_index_error), .oTimeout_error(oTimeout_error),
    .oCrc_error(oCrc_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [RSP_W-1:0] act, input logic [RSP_W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // CRC7 as the remainder of msg * x^7 divided by x^7 + x^3 + 1.
  function automatic logic [6:0] crc7_model(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic [47:0] frame_model(input logic [5:0] idx, input logic [31:0] arg);
    return {2'b01, idx, arg, crc7_model({2'b01, idx, arg}), 1'b1};
  endfunction

  // Monitor: pops an expectation whenever the DUT presents an output event.
  initial begin
    logic prev_strobe;
    prev_strobe = 1'b0;
    forever begin
      @(negedge clk);
      if (oStrobe_out && !prev_strobe) begin
        if (exp_cmd_q.size() == 0) chk("unexpected_strobe", 1, 0);
        else chk("cmd_frame", oCmd_out, exp_cmd_q.pop_front());
      end
      prev_strobe = oStrobe_out;
      if (oAck_out) begin
        if (exp_rsp_q.size() == 0) chk("unexpected_ack", 1, 0);
        else begin
          chk("response", oResponse, exp_rsp_q.pop_front());
          chk("crc_error", oCrc_error, exp_crc_q.pop_front());
        end
      end
      if (oCommand_complete) begin
        if (exp_done_q.size() == 0) chk("unexpected_complete", 1, 0);
        else chk("flags_idx_to_crc", {oCommand_index_error, oTimeout_error, oCrc_error},
                 exp_done_q.pop_front());
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (!oIdle_out && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("idle_return", oIdle_out, 1);
  endtask

  task automatic run_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [1:0] typ,
                         input logic [TO_W-1:0] to, input int k, input logic [RSP_W-1:0] rsp,
                         input bit poke, input bit do_reset, input bit has_lit,
                         input logic [47:0] lit);
    int n;
    bit timeout_exp;
    logic [RSP_W-1:0] exp_rsp;
    logic exp_idx, exp_crc;
    logic [47:0] frame;
    frame = frame_model(idx, arg);
    exp_cmd_q.push_back(frame);
    iCmd_index = idx; iCmd_argument = arg; iRsp_type = typ; iTimeout_cycles = to;
    iNew_command = 1'b1;
    @(posedge clk); #1;
    iNew_command = 1'b0;
    n = 0;
    while (!oStrobe_out && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("strobe_latency", n, 41);
    if (has_lit) chk("frame_literal", oCmd_out, lit);
    if (poke) begin
      iNew_command = 1'b1; iCmd_index = ~idx;
      @(posedge clk); #1;
      iNew_command = 1'b0;
      chk("send_ignores_new_cmd", {oStrobe_out, oCmd_out}, {1'b1, frame});
    end
    timeout_exp = (typ != 2'b00) && (to != '0) && (k >= int'(to));
    exp_rsp = (typ == 2'b10) ? rsp : {{(RSP_W-48){1'b0}}, rsp[47:0]};
    exp_idx = (typ == 2'b01) && (rsp[45:40] != idx);
`ifdef SD_RSP_CRC_CHECK_EN
    exp_crc = (typ != 2'b10) && (crc7_model(rsp[47:8]) != rsp[7:1]);
`else
    exp_crc = 1'b0;
`endif
    if (typ == 2'b00) exp_done_q.push_back(3'b000);
    else if (timeout_exp) exp_done_q.push_back(3'b010);
    else if (!do_reset) begin
      exp_rsp_q.push_back(exp_rsp);
      exp_crc_q.push_back(exp_crc);
      exp_done_q.push_back({exp_idx, 1'b0, exp_crc});
    end
    iAck_in = 1'b1;
    @(posedge clk); #1;
    iAck_in = 1'b0;
    if (typ == 2'b00) begin
      chk("complete_after_ack", oCommand_complete, 1);
      @(posedge clk); #1;
      chk("idle_after_complete", {oIdle_out, oCommand_complete}, 2'b10);
    end else if (timeout_exp) begin
      n = 0;
      while (!oCommand_complete && n < int'(to) + 10) begin
        @(posedge clk); #1; n++;
      end
      chk("timeout_latency", n, to);
    end else if (do_reset) begin
      repeat (3) begin @(posedge clk); #1; end
      iReset_n = 1'b0;
      @(posedge clk); #1;
      iReset_n = 1'b1;
      chk("reset_abort", {oIdle_out, oCommand_complete, oStrobe_out, oAck_out, oTimeout_error},
          5'b10000);
    end else begin
      repeat (k) begin @(posedge clk); #1; end
      chk("no_early_end", {oTimeout_error, oCommand_complete, oIdle_out}, 3'b000);
      iCmd_in = rsp; iStrobe_in = 1'b1;
      @(posedge clk); #1;
      iStrobe_in = 1'b0;
      chk("ack_pulse", oAck_out, 1);
      @(posedge clk); #1;
      chk("ack_one_cycle", oAck_out, 0);
    end
    wait_idle();
  endtask

  function automatic logic [RSP_W-1:0] rand_rsp(input logic [5:0] idx, input logic [1:0] typ);
    logic [159:0] r160;
    logic [RSP_W-1:0] r;
    r160 = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    r = r160[RSP_W-1:0];
    if (typ != 2'b10 && $urandom_range(0, 3) != 0) begin
      r[47:46] = 2'b00;
      if ($urandom_range(0, 1) == 1) r[45:40] = idx;
      if ($urandom_range(0, 1) == 1) r[7:0] = {crc7_model(r[47:8]), 1'b1};
    end
    return r;
  endfunction

  initial begin
    logic [RSP_W-1:0] rsp;
    logic [5:0] idx;
    logic [1:0] typ;
    iReset_n = 1'b0; iNew_command = 1'b0; iCmd_index = '0; iCmd_argument = '0;
    iRsp_type = '0; iTimeout_cycles = '0; iAck_in = 1'b0; iCmd_in = '0; iStrobe_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {oIdle_out, oStrobe_out, oAck_out, oCommand_complete,
        oCommand_index_error, oTimeout_error, oCrc_error, oCmd_out}, {1'b1, 54'd0});
    chk("reset_response", oResponse, 0);
    iReset_n = 1'b1;
    @(posedge clk); #1;

    run_cmd(6'd0, 32'h0, 2'b00, 16'd0, 0, '0, 0, 0, 1, 48'h400000000095);
    rsp = 136'h08000001AA13;
    run_cmd(6'd8, 32'h000001AA, 2'b01, 16'd100, 2, rsp, 0, 0, 1, 48'h48000001AA87);
    rsp[20] = ~rsp[20];
    run_cmd(6'd8, 32'h000001AA, 2'b01, 16'd100, 1, rsp, 0, 0, 1, 48'h48000001AA87);
    rsp = '0;
    rsp[45:40] = 6'd18;
    rsp[7:0] = {crc7_model(rsp[47:8]), 1'b1};
    run_cmd(6'd17, 32'h0, 2'b01, 16'd50, 3, rsp, 0, 0, 1, 48'h510000000055);
    run_cmd(6'd17, 32'h0, 2'b11, 16'd50, 3, rsp, 0, 0, 1, 48'h510000000055);
    run_cmd(6'd2, 32'h0, 2'b10, 16'd5, 1000, '0, 0, 0, 0, '0);
    run_cmd(6'd2, 32'h0, 2'b10, 16'd0, 1000, rand_rsp(6'd2, 2'b10), 0, 0, 0, '0);
    run_cmd(6'd9, 32'h12345678, 2'b01, 16'd5, 4, rand_rsp(6'd9, 2'b01), 0, 0, 0, '0);
    run_cmd(6'd2, 32'h0, 2'b10, 16'd0, 0, '0, 0, 1, 0, '0);
    run_cmd(6'd7, 32'hDEADBEEF, 2'b00, 16'd0, 0, '0, 1, 0, 0, '0);

    for (int i = 0; i < 40; i++) begin
      idx = 6'($urandom_range(0, 63));
      typ = 2'($urandom_range(0, 3));
      run_cmd(idx, $urandom(), typ, 16'($urandom_range(0, 12)), $urandom_range(0, 14),
              rand_rsp(idx, typ), 0, 0, 0, '0);
    end

    repeat (3) @(negedge clk);
    chk("queues_drained", exp_cmd_q.size() + exp_rsp_q.size() + exp_done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    n_vec++;
    n_miss++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
